// File: rtl/sort_arb_pkg.sv
// Shared types for the sorting-engine packet arbiter: FSM state encoding
// and the channel-index width helper.
package sort_arb_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    FWD_S  = 1'b1
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int calc_chw(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Show-ahead FIFO holding the originating channel of every packet that is
// inside the sorting engine. DEPTH must be a power of two, at least 2.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sort_pkt_arbiter.sv
// Round-robin packet arbiter feeding a shared sorting engine; the channel of
// each packet is queued so the sorted result can be tagged on its way out.
module sort_pkt_arbiter
  import sort_arb_pkg::*;
#(
  parameter  int DWIDTH    = 16,
  parameter  int NUM_CH    = 4,
  parameter  int TAG_DEPTH = 4,
  localparam int CHW       = calc_chw(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     srst_ni,
  input  logic [NUM_CH*DWIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]        in_startofpacket_i,
  input  logic [NUM_CH-1:0]        in_endofpacket_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic [DWIDTH-1:0]        srt_data_o,
  output logic                     srt_startofpacket_o,
  output logic                     srt_endofpacket_o,
  output logic                     srt_valid_o,
  input  logic                     srt_ready_i,
  input  logic [DWIDTH-1:0]        ret_data_i,
  input  logic                     ret_startofpacket_i,
  input  logic                     ret_endofpacket_i,
  input  logic                     ret_valid_i,
  output logic                     ret_ready_o,
  output logic [DWIDTH-1:0]        out_data_o,
  output logic                     out_startofpacket_o,
  output logic                     out_endofpacket_o,
  output logic                     out_valid_o,
  output logic [CHW-1:0]           out_channel_o,
  input  logic                     out_ready_i,
  output logic                     err_o
);

  state_t           state_reg;
  logic [CHW-1:0]   grant_reg;
  logic [CHW-1:0]   rr_ptr_reg;
  logic [CHW-1:0]   rr_ptr_next;
  logic             err_reg;

  logic [DWIDTH-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] cand;
  logic [CHW-1:0]    pick;
  logic              pick_found;
  logic              grant_take;
  logic              fwd;
  logic              srt_acc;
  logic              ret_acc;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CHW-1:0]    fifo_head;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data_i[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  assign cand = in_valid_i & in_startofpacket_i;

  // First packet-start candidate at or above rr_ptr, wrapping around.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_found && cand[(int'(rr_ptr_reg) + i) % NUM_CH]) begin
        pick_found = 1'b1;
        pick       = CHW'((int'(rr_ptr_reg) + i) % NUM_CH);
      end
    end
  end

  assign rr_ptr_next = CHW'((int'(pick) + 1) % NUM_CH);
  assign grant_take  = (state_reg == IDLE_S) && pick_found && !fifo_full;
  assign fwd         = (state_reg == FWD_S);

  assign srt_data_o          = ch_data[grant_reg];
  assign srt_valid_o         = fwd && in_valid_i[grant_reg];
  assign srt_startofpacket_o = fwd && in_startofpacket_i[grant_reg];
  assign srt_endofpacket_o   = fwd && in_endofpacket_i[grant_reg];
  assign srt_acc             = srt_valid_o && srt_ready_i;

  // Idle: swallow beats that arrive without a packet start so they cannot stall a channel.
  always_comb begin
    in_ready_o = '0;
    if (fwd) in_ready_o[grant_reg] = srt_ready_i;
    else     in_ready_o = in_valid_i & ~in_startofpacket_i;
  end

  assign out_data_o          = ret_data_i;
  assign out_startofpacket_o = ret_startofpacket_i;
  assign out_endofpacket_o   = ret_endofpacket_i;
  assign out_valid_o         = ret_valid_i;
  assign ret_ready_o         = out_ready_i;
  assign ret_acc             = ret_valid_i && out_ready_i;
  assign out_channel_o       = fifo_empty ? '0 : fifo_head;
  assign err_o               = err_reg;

  assign fifo_push = srt_acc && srt_startofpacket_o;
  assign fifo_pop  = ret_acc && ret_endofpacket_i && !fifo_empty;

  tag_fifo #(
    .WIDTH (CHW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .srst_ni     (srst_ni),
    .push_i      (fifo_push),
    .push_data_i (grant_reg),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      state_reg  <= IDLE_S;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (ret_acc && fifo_empty) err_reg <= 1'b1;
      case (state_reg)
        IDLE_S: begin
          if (grant_take) begin
            grant_reg  <= pick;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= FWD_S;
          end
        end
        FWD_S: begin
          if (srt_acc && in_endofpacket_i[grant_reg]) state_reg <= IDLE_S;
        end
        default: state_reg <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// Directed bench for sort_pkt_arbiter: the sorting engine is played by hand
// through the ret_* inputs.
module tb_sort_pkt_arbiter;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int TD  = 4;
  localparam int CHW = 2;

  logic              clk_i = 1'b0;
  logic              srst_ni;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_sop, in_eop, in_valid, in_ready;
  logic [DW-1:0]     srt_data;
  logic              srt_sop, srt_eop, srt_valid, srt_ready;
  logic [DW-1:0]     ret_data;
  logic              ret_sop, ret_eop, ret_valid, ret_ready;
  logic [DW-1:0]     out_data;
  logic              out_sop, out_eop, out_valid, out_ready;
  logic [CHW-1:0]    out_channel;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sort_pkt_arbiter #(.DWIDTH(DW), .NUM_CH(NCH), .TAG_DEPTH(TD)) dut (
    .clk_i               (clk_i),
    .srst_ni             (srst_ni),
    .in_data_i           (in_data),
    .in_startofpacket_i  (in_sop),
    .in_endofpacket_i    (in_eop),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .srt_data_o          (srt_data),
    .srt_startofpacket_o (srt_sop),
    .srt_endofpacket_o   (srt_eop),
    .srt_valid_o         (srt_valid),
    .srt_ready_i         (srt_ready),
    .ret_data_i          (ret_data),
    .ret_startofpacket_i (ret_sop),
    .ret_endofpacket_i   (ret_eop),
    .ret_valid_i         (ret_valid),
    .ret_ready_o         (ret_ready),
    .out_data_o          (out_data),
    .out_startofpacket_o (out_sop),
    .out_endofpacket_o   (out_eop),
    .out_valid_o         (out_valid),
    .out_channel_o       (out_channel),
    .out_ready_i         (out_ready),
    .err_o               (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    in_valid[k]          = v;
    in_sop[k]            = s;
    in_eop[k]            = e;
    in_data[k*DW +: DW]  = d;
  endtask

  task automatic ret(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    ret_valid = v;
    ret_sop   = s;
    ret_eop   = e;
    ret_data  = d;
  endtask

  // Single-beat return packet; checks the channel tag attached to it.
  task automatic ret_one(input string tag, input logic [CHW-1:0] exp_ch);
    ret(1'b1, 1'b1, 1'b1, 16'h00AA);
    #1;
    check(tag, out_channel, exp_ch);
    $display("return packet: channel %0d", out_channel);
    tick();
    ret(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [CHW-1:0] drain_seq [4];
    logic [DW-1:0]  sorted [3];
    drain_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    sorted    = '{16'd2, 16'd5, 16'd9};

    srst_ni   = 1'b0;
    in_data   = '0;
    in_sop    = '0;
    in_eop    = '0;
    in_valid  = '0;
    srt_ready = 1'b1;
    out_ready = 1'b1;
    ret(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    check("rst_srt_valid", srt_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_err", err, 0);
    check("rst_out_channel", out_channel, 0);
    srst_ni = 1'b1;

    // Three-beat packet on channel 1 with one stalled beat.
    drive(1, 1, 1, 0, 16'd5);
    #1;
    check("p1_idle_valid", srt_valid, 0);
    check("p1_idle_ready", in_ready, 0);
    tick();
    check("p1_b0_valid", srt_valid, 1);
    check("p1_b0_data", srt_data, 5);
    check("p1_b0_sop", srt_sop, 1);
    check("p1_b0_ready", in_ready, 4'b0010);
    tick();
    drive(1, 1, 0, 0, 16'd2);
    srt_ready = 1'b0;
    #1;
    check("p1_stall_valid", srt_valid, 1);
    check("p1_stall_ready", in_ready, 0);
    tick();
    srt_ready = 1'b1;
    #1;
    check("p1_b1_data", srt_data, 2);
    check("p1_b1_sop", srt_sop, 0);
    check("p1_b1_ready", in_ready, 4'b0010);
    tick();
    drive(1, 1, 0, 1, 16'd9);
    #1;
    check("p1_b2_data", srt_data, 9);
    check("p1_b2_eop", srt_eop, 1);
    tick();
    drive(1, 0, 0, 0, 16'd0);
    #1;
    check("p1_done_valid", srt_valid, 0);
    $display("packet ch1 forwarded: 5,2,9");
    for (int i = 0; i < 3; i++) begin
      ret(1'b1, i == 0, i == 2, sorted[i]);
      #1;
      check("p1_ret_channel", out_channel, 1);
      check("p1_ret_data", out_data, sorted[i]);
      check("p1_ret_valid", out_valid, 1);
      tick();
    end
    ret(1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("p1_ret_empty_ch", out_channel, 0);
    check("p1_err", err, 0);

    // All four channels start together from reset: round-robin 0..3, FIFO fills.
    srst_ni = 1'b0;
    tick();
    srst_ni = 1'b1;
    for (int k = 0; k < NCH; k++) drive(k, 1, 1, 1, 16'h10 + 16'(k));
    #1;
    for (int k = 0; k < NCH; k++) begin
      check("rr_idle_valid", srt_valid, 0);
      check("rr_idle_ready", in_ready, 0);
      tick();
      check("rr_data", srt_data, 16'h10 + k);
      check("rr_ready", in_ready, 4'b0001 << k);
      check("rr_sop_eop", {srt_sop, srt_eop}, 2'b11);
      $display("packet ch%0d forwarded: %0h", k, srt_data);
      tick();
      drive(k, 0, 0, 0, 16'd0);
      #1;
    end

    // FIFO full: ch0 and ch2 wait with no grant.
    drive(0, 1, 1, 1, 16'h20);
    drive(2, 1, 1, 1, 16'h22);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("full_srt_valid", srt_valid, 0);
      check("full_in_ready", in_ready, 0);
      tick();
    end
    ret_one("full_pop_ch", 2'd0);
    #1;
    check("after_pop_idle", srt_valid, 0);
    tick();
    check("wrap_data", srt_data, 16'h20);
    check("wrap_ready", in_ready, 4'b0001);
    drive(2, 0, 0, 0, 16'd0);
    tick();
    drive(0, 0, 0, 0, 16'd0);
    for (int i = 0; i < 4; i++) ret_one("drain_ch", drain_seq[i]);
    #1;
    check("drain_empty_ch", out_channel, 0);
    check("drain_err", err, 0);

    // Back-to-back single-beat packets on channel 2.
    drive(2, 1, 1, 1, 16'h0A1);
    #1;
    check("bb_idle0", srt_valid, 0);
    tick();
    check("bb_p0_data", srt_data, 16'h0A1);
    check("bb_p0_flags", {srt_valid, srt_sop, srt_eop}, 3'b111);
    tick();
    drive(2, 1, 1, 1, 16'h0A2);
    #1;
    check("bb_gap_valid", srt_valid, 0);
    check("bb_gap_ready", in_ready, 0);
    tick();
    check("bb_p1_data", srt_data, 16'h0A2);
    check("bb_p1_flags", {srt_valid, srt_sop, srt_eop}, 3'b111);
    tick();
    drive(2, 0, 0, 0, 16'd0);
    ret_one("bb_ret0", 2'd2);
    ret_one("bb_ret1", 2'd2);

    // Stray beat drained in idle; return with empty FIFO raises err.
    drive(3, 1, 0, 0, 16'h33);
    #1;
    check("stray_ready", in_ready, 4'b1000);
    check("stray_valid", srt_valid, 0);
    tick();
    drive(3, 0, 0, 0, 16'd0);
    out_ready = 1'b0;
    ret(1'b1, 1'b1, 1'b1, 16'h0BAD);
    #1;
    check("ret_ready_follow", ret_ready, 0);
    tick();
    check("err_not_accepted", err, 0);
    out_ready = 1'b1;
    #1;
    check("orphan_valid", out_valid, 1);
    check("orphan_data", out_data, 16'h0BAD);
    check("orphan_channel", out_channel, 0);
    tick();
    ret(1'b0, 1'b0, 1'b0, 16'h0000);
    check("err_set", err, 1);
    tick();
    tick();
    check("err_sticky", err, 1);

    // Reset in the middle of a channel-1 packet.
    drive(1, 1, 1, 0, 16'h51);
    #1;
    tick();
    check("mid_b0_data", srt_data, 16'h51);
    tick();
    drive(1, 1, 0, 0, 16'h52);
    #1;
    check("mid_b1_valid", srt_valid, 1);
    check("mid_tag", out_channel, 1);
    srst_ni = 1'b0;
    tick();
    srst_ni = 1'b1;
    #1;
    check("mrst_srt_valid", srt_valid, 0);
    check("mrst_drain", in_ready, 4'b0010);
    check("mrst_fifo", out_channel, 0);
    check("mrst_err", err, 0);
    drive(1, 0, 0, 0, 16'd0);
    drive(0, 1, 1, 1, 16'h60);
    drive(3, 1, 1, 1, 16'h63);
    #1;
    tick();
    check("mrst_grant_data", srt_data, 16'h60);
    check("mrst_grant_ready", in_ready, 4'b0001);
    tick();
    drive(0, 0, 0, 0, 16'd0);
    drive(3, 0, 0, 0, 16'd0);
    ret_one("mrst_ret_ch", 2'd0);
    #1;
    check("mrst_ret_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_pkt_arbiter.md
SORT_PKT_ARBITER -- requirements
Module: sort_pkt_arbiter

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 16, data beat width; NUM_CH, default 4, number of requesting streams (>=2); TAG_DEPTH, default 4, depth of the channel-tag FIFO (power of 2). CHW = max(1, $clog2(NUM_CH)).
REQ-002 Ports SHALL be: clk_i  in  1  clock; srst_ni  in  1  reset, synchronous, active-low.
REQ-003 Ports SHALL be: in_data_i  in  NUM_CH x DWIDTH  request data; in_startofpacket_i, in_endofpacket_i, in_valid_i  in  NUM_CH  per-channel Avalon-ST flags; in_ready_o  out  NUM_CH  per-channel ready.
REQ-004 Ports SHALL be: srt_data_o  out  DWIDTH, srt_startofpacket_o, srt_endofpacket_o, srt_valid_o  out  1  stream to sorting engine sink; srt_ready_i  in  1  engine sink ready.
REQ-005 Ports SHALL be: ret_data_i  in  DWIDTH, ret_startofpacket_i, ret_endofpacket_i, ret_valid_i  in  1  sorted stream from engine source; ret_ready_o  out  1.
REQ-006 Ports SHALL be: out_data_o  out  DWIDTH, out_startofpacket_o, out_endofpacket_o, out_valid_o  out  1, out_channel_o  out  CHW  originating channel; out_ready_i  in  1; err_o  out  1  sticky protocol error.

Function
REQ-007 FSM SHALL have states IDLE_S and FWD_S; the grant index (CHW bits) SHALL be a register.
REQ-008 In IDLE_S, a channel SHALL be a candidate when in_valid_i[k] && in_startofpacket_i[k]; if any candidate exists and the tag FIFO is not full, the grant SHALL register the first candidate searching from rr_ptr upward modulo NUM_CH, and the state SHALL go to FWD_S next cycle.
REQ-009 On a grant to channel g, rr_ptr SHALL become (g+1) mod NUM_CH.
REQ-010 In IDLE_S, in_ready_o[k] SHALL be 1 only for channels with in_valid_i[k] && !in_startofpacket_i[k] (stray beats drained and discarded); all srt_* valid SHALL be 0.
REQ-011 In FWD_S, srt_data/sop/eop/valid SHALL equal channel g's inputs combinationally, in_ready_o[g] = srt_ready_i, all other in_ready_o = 0 (zero-cycle passthrough, grant-to-first-beat latency 1 cycle).
REQ-012 On an accepted beat (srt_valid_o && srt_ready_i) with startofpacket, g SHALL be pushed into the tag FIFO; with endofpacket, state SHALL return to IDLE_S next cycle; a single-beat packet (sop and eop) SHALL do both.
REQ-013 Return path SHALL be passthrough: out_data/sop/eop/valid = ret_*, ret_ready_o = out_ready_i, out_channel_o = tag FIFO head.
REQ-014 On an accepted return beat with endofpacket, the tag FIFO SHALL pop; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-015 An accepted return beat while the tag FIFO is empty SHALL set err_o (held until reset), SHALL still be forwarded with out_channel_o = 0, and SHALL not pop.
REQ-016 A new grant SHALL be taken in the cycle after an eop at the earliest (one idle cycle between packets).

Reset
REQ-017 While srst_ni = 0 at a clock edge: state = IDLE_S, grant = 0, rr_ptr = 0, tag FIFO empty, err_o = 0; reset mid-packet SHALL discard the partial packet and all tags (the sorting engine shares the reset).
REQ-018 No registered output SHALL be X after the first reset edge; combinational outputs SHALL follow REQ-010..013 from reset state.

Structure
REQ-019 Package sort_arb_pkg SHALL hold the state enum typedef and a function computing CHW.
REQ-020 The tag FIFO SHALL be a sub-module tag_fifo (width CHW, depth TAG_DEPTH, full/empty, show-ahead read).

Verification
REQ-021 Ch1 sends 3-beat packet {5,2,9}, others idle -> grant 1 one cycle after sop, srt sees 5,2,9 with sop/eop, returned packet has out_channel_o = 1.
REQ-022 Ch0..3 all present sop simultaneously from reset -> packets forwarded in order 0,1,2,3, then rr_ptr wraps to 0.
REQ-023 Single-beat packets back-to-back on ch2 -> each forwarded with sop=eop=1, one idle cycle between, tags pushed each.
REQ-024 TAG_DEPTH packets forwarded, no returns -> no new grant, in_ready_o all 0 until one return eop pops.
REQ-025 Return beat with empty FIFO -> err_o = 1 persistent, out_channel_o = 0; ch3 non-sop beat in IDLE_S -> drained, not forwarded.
REQ-026 srst_ni low mid-packet on ch1 -> next cycle state IDLE_S, FIFO empty, rr_ptr = 0, fresh packet on ch0 forwarded normally.
